// File: rtl/mode_count.sv
// ---------------------------------------------------------------------------
// mode_count: parametrised up/down counter with programmable modulus,
// wrap/saturate boundary handling, parallel load, enable prescaler,
// a one-cycle terminal-count pulse and a sticky boundary flag.
//
// Parameters
//   W         counter width in bits (>= 2)
//   PRESCALE  enabled cycles per count step (>= 1, 1 = every enabled cycle)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   en         in   count enable, feeds the prescaler
//   load       in   synchronous parallel load strobe
//   load_val   in   W  load value (clipped to modulus)
//   dir        in   1 = up, 0 = down
//   mode       in   0 = wrap at boundary, 1 = saturate at boundary
//   modulus    in   W  upper count limit, range is 0..modulus
//   clr_flags  in   synchronous clear of ovf
//   count      out  W  registered count
//   tc         out  registered one-cycle terminal-count pulse
//   ovf        out  registered sticky boundary flag
//   zero       out  combinational, count == 0
// ---------------------------------------------------------------------------
module mode_count #(
    parameter int W        = 4,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dir,
    input  logic         mode,
    input  logic [W-1:0] modulus,
    input  logic         clr_flags,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         ovf,
    output logic         zero
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;
    logic [W-1:0]  r_count;
    logic          r_tc;
    logic          r_ovf;

    logic          w_step;
    logic          w_boundary;
    logic [W-1:0]  w_load_clip;
    logic [W-1:0]  w_step_val;

    assign w_step = en && (r_pre == PRE_LAST);

    // ">=" on the way up so a count stranded above a freshly lowered
    // modulus is treated as a boundary rather than running on to wrap at 2^W.
    assign w_boundary  = dir ? (r_count >= modulus) : (r_count == '0);
    assign w_load_clip = (load_val > modulus) ? modulus : load_val;

    always_comb begin
        w_step_val = r_count;
        if (w_boundary) begin
            if (dir) w_step_val = mode ? modulus : '0;
            else     w_step_val = mode ? '0      : modulus;
        end else begin
            w_step_val = dir ? (r_count + W'(1)) : (r_count - W'(1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load) begin
            // A load drops any coincident step and restarts the prescaler phase.
            r_count <= w_load_clip;
            r_pre   <= '0;
            r_tc    <= 1'b0;
            if (clr_flags) r_ovf <= 1'b0;
        end else begin
            if (en) r_pre <= w_step ? '0 : (r_pre + PW'(1));
            if (w_step) begin
                r_count <= w_step_val;
                r_tc    <= w_boundary;
                // A boundary event on the same edge beats a flag clear.
                if (w_boundary)     r_ovf <= 1'b1;
                else if (clr_flags) r_ovf <= 1'b0;
            end else begin
                r_tc <= 1'b0;
                if (clr_flags) r_ovf <= 1'b0;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;
    assign zero  = (r_count == '0);

endmodule
